// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: routes the hps_io download stream to the core ROM, game-select and DIP registers,
// and holds the core in reset through power-up, every download and a fixed period afterwards.
module rom_load_ctrl #(
  parameter int RESET_HOLD = 16,
  parameter int MOD_COUNT  = 18
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [7:0]           ioctl_index,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 user_reset,
  output logic                 rom_wr,
  output logic [15:0]          rom_addr,
  output logic [7:0]           rom_data,
  output logic [7:0]           mod_sel,
  output logic [MOD_COUNT-1:0] mod_onehot,
  output logic [63:0]          dip_sw,
  output logic                 core_reset,
  output logic                 loaded,
  output logic                 rom_ovf
);
  localparam int HOLD_N = RESET_HOLD < 1 ? 1 : RESET_HOLD;
  localparam int CW = HOLD_N > 1 ? $clog2(HOLD_N) : 1;
  typedef enum logic [1:0] {BOOT, LOAD, HOLD, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dl_q, rise, core_reset_q;
  logic rom_acc, rom_drop, mod_we, dip_we;
  logic rom_wr_q, loaded_q, rom_ovf_q;
  logic [15:0] rom_addr_q;
  logic [7:0] rom_data_q, mod_sel_q;
  logic [MOD_COUNT-1:0] onehot_q, onehot_d;
  logic [63:0] dip_q;
  assign rise     = ioctl_download & ~dl_q;
  assign rom_acc  = ioctl_wr && ioctl_index == 8'd0 && ioctl_addr[24:16] == 9'd0;
  assign rom_drop = ioctl_wr && ioctl_index == 8'd0 && ioctl_addr[24:16] != 9'd0;
  assign mod_we   = ioctl_wr && ioctl_index == 8'd1;
  assign dip_we   = ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT, RUN: state_d = rise ? LOAD : state_q;
      LOAD: if (!ioctl_download) begin
        state_d = HOLD;
        cnt_d   = CW'(HOLD_N - 1);
      end
      HOLD: if (rise) state_d = LOAD;
      else if (cnt_q == '0) state_d = RUN;
      else cnt_d = cnt_q - 1'b1;
    endcase
  end
  always_comb begin
    onehot_d = '0;
    for (int k = 0; k < MOD_COUNT; k++) onehot_d[k] = mod_sel_q == 8'(k);
  end
  // core_reset is computed from the next state so it changes together with the state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= BOOT;
      cnt_q        <= '0;
      dl_q         <= 1'b0;
      core_reset_q <= 1'b1;
      rom_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      mod_sel_q    <= '0;
      onehot_q     <= MOD_COUNT'(1);
      dip_q        <= '1;
      loaded_q     <= 1'b0;
      rom_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_q         <= ioctl_download;
      core_reset_q <= state_d == RUN ? user_reset : 1'b1;
      rom_wr_q     <= rom_acc;
      if (rom_acc) begin
        rom_addr_q <= ioctl_addr[15:0];
        rom_data_q <= ioctl_dout;
      end
      if (mod_we) mod_sel_q <= ioctl_dout;
      onehot_q     <= onehot_d;
      if (dip_we) dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      loaded_q     <= loaded_q | rom_acc;
      rom_ovf_q    <= rom_ovf_q | rom_drop;
    end
  end
  assign rom_wr     = rom_wr_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign mod_sel    = mod_sel_q;
  assign mod_onehot = onehot_q;
  assign dip_sw     = dip_q;
  assign core_reset = core_reset_q;
  assign loaded     = loaded_q;
  assign rom_ovf    = rom_ovf_q;
endmodule
